// File: rtl/mode_scheduler_if.sv
// Key-request and mode-status bundle between the keypad front end and mode_scheduler.
`ifndef OFF_MODE
`define OFF_MODE       3'd0
`define STAND_MODE     3'd1
`define EXTRACT_MODE_1 3'd2
`define EXTRACT_MODE_2 3'd3
`define EXTRACT_MODE_3 3'd4
`define CLEAN_MODE     3'd5
`endif

interface mode_scheduler_if #(
  parameter int MODE_WIDTH = 3
);
  logic                  tick_1s;
  logic                  power_req;
  logic                  clean_req;
  logic                  lvl1_req;
  logic                  lvl2_req;
  logic                  lvl3_req;
  logic                  menu_req;
  logic [MODE_WIDTH-1:0] current_mode;
  logic [7:0]            remaining_s;
  logic                  lvl3_used;

  modport master (
    output tick_1s, power_req, clean_req, lvl1_req, lvl2_req, lvl3_req, menu_req,
    input  current_mode, remaining_s, lvl3_used
  );
  modport slave (
    input  tick_1s, power_req, clean_req, lvl1_req, lvl2_req, lvl3_req, menu_req,
    output current_mode, remaining_s, lvl3_used
  );
endinterface

// File: rtl/mode_scheduler.sv
// Appliance mode FSM: edge-detected key requests, timed CLEAN / EXTRACT_MODE_3
// countdowns driven by a 1 s tick, and a once-per-power-on level-3 lockout.
`ifndef OFF_MODE
`define OFF_MODE       3'd0
`define STAND_MODE     3'd1
`define EXTRACT_MODE_1 3'd2
`define EXTRACT_MODE_2 3'd3
`define EXTRACT_MODE_3 3'd4
`define CLEAN_MODE     3'd5
`endif

module mode_scheduler #(
  parameter int MODE_WIDTH = 3,
  parameter int CLEAN_TIME = 180,
  parameter int LVL3_TIME  = 60
) (
  input  logic            clk,
  input  logic            rstn,
  mode_scheduler_if.slave bus
);
  typedef enum logic [MODE_WIDTH-1:0] {
    OFF   = MODE_WIDTH'(`OFF_MODE),
    STAND = MODE_WIDTH'(`STAND_MODE),
    EXT1  = MODE_WIDTH'(`EXTRACT_MODE_1),
    EXT2  = MODE_WIDTH'(`EXTRACT_MODE_2),
    EXT3  = MODE_WIDTH'(`EXTRACT_MODE_3),
    CLEAN = MODE_WIDTH'(`CLEAN_MODE)
  } mode_t;

  typedef struct packed {
    logic power;
    logic clean;
    logic lvl3;
    logic lvl2;
    logic lvl1;
    logic menu;
  } req_t;

  req_t       req, prev, rise;
  mode_t      mode, mode_nxt;
  logic [7:0] rem, rem_nxt;
  logic       used, used_nxt;
  logic       armed;
  logic       taken;

  assign req = {bus.power_req, bus.clean_req, bus.lvl3_req,
                bus.lvl2_req, bus.lvl1_req, bus.menu_req};

  // First cycle out of reset only captures levels, so a key already held is not an edge.
  assign rise = armed ? (req & ~prev) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode  <= OFF;
      rem   <= '0;
      used  <= 1'b0;
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      mode  <= mode_nxt;
      rem   <= rem_nxt;
      used  <= used_nxt;
      prev  <= req;
      armed <= 1'b1;
    end
  end

  // Highest-priority edge is the only one considered; if the mode ignores it, the
  // lower edges of that cycle are still dropped.
  always_comb begin
    mode_nxt = mode;
    rem_nxt  = rem;
    used_nxt = used;
    taken    = 1'b0;
    if (rise.power) begin
      taken = 1'b1;
      if (mode == OFF) begin
        mode_nxt = STAND;
      end else begin
        mode_nxt = OFF;
        rem_nxt  = '0;
        used_nxt = 1'b0;
      end
    end else begin
      case (mode)
        OFF: ;
        STAND, EXT1, EXT2: begin
          if (rise.clean) begin
            if (mode == STAND) begin
              taken    = 1'b1;
              mode_nxt = CLEAN;
              rem_nxt  = 8'(CLEAN_TIME);
            end
          end else if (rise.lvl3) begin
            if (!used) begin
              taken    = 1'b1;
              mode_nxt = EXT3;
              rem_nxt  = 8'(LVL3_TIME);
              used_nxt = 1'b1;
            end
          end else if (rise.lvl2) begin
            taken    = 1'b1;
            mode_nxt = EXT2;
          end else if (rise.lvl1) begin
            taken    = 1'b1;
            mode_nxt = EXT1;
          end else if (rise.menu && mode != STAND) begin
            taken    = 1'b1;
            mode_nxt = STAND;
          end
        end
        EXT3: begin
          if (!(rise.clean || rise.lvl3 || rise.lvl2 || rise.lvl1) && rise.menu) begin
            taken    = 1'b1;
            mode_nxt = STAND;
            rem_nxt  = '0;
          end
        end
        CLEAN: ;
        default: begin
          taken    = 1'b1;
          mode_nxt = OFF;
          rem_nxt  = '0;
          used_nxt = 1'b0;
        end
      endcase
    end

    if (!taken && bus.tick_1s && (mode == EXT3 || mode == CLEAN) && rem != 8'd0) begin
      if (rem == 8'd1) begin
        mode_nxt = (mode == EXT3) ? EXT2 : STAND;
        rem_nxt  = '0;
      end else begin
        rem_nxt = rem - 8'd1;
      end
    end
  end

  assign bus.current_mode = mode;
  assign bus.remaining_s  = rem;
  assign bus.lvl3_used    = used;

endmodule
